multi_count_block: RTL
======================

Name: multi_count_block

Overview:
- Multi-channel, runtime-programmable successor to the fixed-terminal enable-counting block.
- Each channel counts enabled clock cycles and emits a single-cycle registered pulse when its programmed terminal count is reached.
- Each channel runs in periodic mode (auto-restart) or one-shot mode (stop and flag done).
- Used for baud, debounce and frame-rate tick generation where several independent dividers share one clock.

Parameters:
- N, 8, counter and terminal-count width per channel.
- CH, 2, number of independent channels.
- DEFAULT_TC, 11, terminal count loaded into every channel at reset; truncated to N bits.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting clears all state immediately, release is synchronised externally.
- en  input  CH  per-channel count enable.
- clr  input  CH  per-channel synchronous clear of count and done.
- load  input  CH  per-channel strobe: capture load_val as new terminal count.
- load_val  input  N  shared terminal-count value for any channel strobing load.
- mode  input  CH  per-channel mode: 0 = periodic, 1 = one-shot.
- q  output  CH  per-channel terminal pulse, one cycle wide, registered.
- done  output  CH  per-channel sticky one-shot completion flag.
- count  output  CH*N  concatenated current counts; channel i occupies bits [i*N +: N].

Behaviour:
- Per channel i, registers are cnt[N], tc[N], q, done.
- Channels are fully independent; there is no cross-channel interaction other than the shared load_val.
- Reset (reset low, asynchronous): cnt=0, tc=DEFAULT_TC[N-1:0], q=0, done=0 on all channels.
- Effective period P = tc, except tc=0 means P = 2^N. Hit condition: en[i] && cnt == P-1 (modulo 2^N).
- Per-cycle priority: clr > load > en.
  - clr[i]=1: cnt<=0, done<=0, q<=0; tc unchanged; en ignored this cycle.
  - load[i]=1 (no clr): tc<=load_val, cnt<=0, done<=0, q<=0; en ignored this cycle.
  - Otherwise, en=1, not done, no hit: cnt<=cnt+1, q<=0.
  - Otherwise, hit: cnt<=0, q<=1 in the following cycle, for exactly one cycle.
    - If mode=1 (one-shot), also done<=1.
  - Otherwise: cnt holds, q<=0.
- Latency: q rises on the clock edge that registers the P-th enabled cycle and is visible the cycle after that enable was sampled high. Back-to-back hits with P=1 give q continuously high while en is high (periodic mode).
- One-shot: once done=1, en is ignored and cnt stays 0, q stays 0, until clr or load. Periodic mode never sets done.
- mode is sampled at each hit, so a mid-count change of mode affects only the next hit. Changing mode while done=1 does not clear done.
- Loading a tc at or below the current cnt takes effect cleanly because load also zeroes cnt.
- The count output reflects cnt registers directly, with no extra latency.
- Gaps in en stall the count; there is no timeout.

Test Plan:
- Reset release, CH=2, N=8, en[0] held high, mode=0 -> q[0] high for one cycle after enabled cycles 11, 22, 33; count[7:0] sequence 0..10,0..; done[0] stays 0.
- en[1] toggled 1,0,1,0..., mode=0, default tc -> q[1] pulses once per 22 clocks; count holds during en=0 cycles.
- load[1] with load_val=3, then mode[1]=1, en[1] high -> q[1] pulses once after 3rd enabled cycle; done[1]=1; further en gives count 0 and no pulse; clr[1] -> done[1]=0, counting resumes.
- N=4, load_val=0, en high -> q pulses every 16 enabled cycles; load_val=1 -> q continuously high while en high.
- cnt at P-1 with en, clr and load all high in the same cycle -> no pulse, cnt=0, tc unchanged (clr wins).
- Assert reset mid-count (cnt=7) asynchronously between edges -> count, q, done zero immediately; tc back to 11; counting after release starts from 0.

Source files
------------

// File: rtl/multi_count_block.sv
// Multi-channel enable counter with runtime-programmable terminal count.
// Each channel emits a one-cycle registered pulse per period, either periodically or as a one-shot.
module multi_count_block #(
    parameter int unsigned N          = 8,
    parameter int unsigned CH         = 2,
    parameter int unsigned DEFAULT_TC = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   clr,
    input  logic [CH-1:0]   load,
    input  logic [N-1:0]    load_val,
    input  logic [CH-1:0]   mode,
    output logic [CH-1:0]   q,
    output logic [CH-1:0]   done,
    output logic [CH*N-1:0] count
);

    localparam logic [N-1:0] TC_RST = N'(DEFAULT_TC);
    localparam logic [N-1:0] ONE    = N'(1);

    logic [N-1:0]  cnt_q [CH];
    logic [N-1:0]  cnt_d [CH];
    logic [N-1:0]  tc_q  [CH];
    logic [N-1:0]  tc_d  [CH];
    logic [CH-1:0] q_q, q_d;
    logic [CH-1:0] done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = tc_q;
        q_d    = '0;
        done_d = done_q;
        for (int unsigned i = 0; i < CH; i++) begin
            if (clr[i]) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (load[i]) begin
                tc_d[i]   = load_val;
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (en[i] && !done_q[i]) begin
                // tc==0 wraps to all-ones, giving a period of 2^N
                if (cnt_q[i] == tc_q[i] - ONE) begin
                    cnt_d[i] = '0;
                    q_d[i]   = 1'b1;
                    if (mode[i]) begin
                        done_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
                tc_q[i]  <= TC_RST;
            end
            q_q    <= '0;
            done_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            q_q    <= q_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            count[i*N +: N] = cnt_q[i];
        end
    end

    assign q    = q_q;
    assign done = done_q;

endmodule
